// File: rtl/beamform_pkg.sv
// Shared beamformer definitions: word widths, combiner FSM states and the
// round-half-up / saturate helper used on every complex output component.
package beamform_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int RND_W      = 64;

    localparam logic signed [RND_W-1:0] ONE   = 1;
    localparam logic signed [RND_W-1:0] Y_MAX = (ONE <<< (DATA_W_DEF - 1)) - ONE;
    localparam logic signed [RND_W-1:0] Y_MIN = -(ONE <<< (DATA_W_DEF - 1));

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    typedef struct packed {
        logic                         clip;
        logic signed [DATA_W_DEF-1:0] y;
    } round_t;

    // Headroom for N full-precision conj(w)*x terms with no wrap.
    function automatic int acc_width(input int data_w, input int n_elem);
        return 2 * data_w + 1 + $clog2(n_elem);
    endfunction

    function automatic round_t sat_round(input logic signed [RND_W-1:0] acc,
                                         input int shift);
        logic signed [RND_W-1:0] r;
        round_t                  res;
        r = (acc + (ONE <<< (shift - 1))) >>> shift;
        if (r > Y_MAX) begin
            res.clip = 1'b1;
            res.y    = Y_MAX[DATA_W_DEF-1:0];
        end else if (r < Y_MIN) begin
            res.clip = 1'b1;
            res.y    = Y_MIN[DATA_W_DEF-1:0];
        end else begin
            res.clip = 1'b0;
            res.y    = r[DATA_W_DEF-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/cmul_conj.sv
// Two-stage conj(w)*x multiplier: products, then re/im sums, with the
// valid/first/last tags travelling alongside the data.
module cmul_conj
    import beamform_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic signed [DATA_W-1:0]   w_i,
    input  logic signed [DATA_W-1:0]   w_q,
    input  logic signed [DATA_W-1:0]   x_i,
    input  logic signed [DATA_W-1:0]   x_q,
    output logic                       out_valid,
    output logic                       out_first,
    output logic                       out_last,
    output logic signed [2*DATA_W:0]   re,
    output logic signed [2*DATA_W:0]   im
);

    localparam int P_W = 2 * DATA_W;
    localparam int S_W = 2 * DATA_W + 1;

    logic                  v1, f1, l1;
    logic signed [P_W-1:0] p_ii, p_qq, p_iq, p_qi;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            f1        <= 1'b0;
            l1        <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            v1        <= in_valid;
            f1        <= in_first;
            l1        <= in_last;
            out_valid <= v1;
            out_first <= f1;
            out_last  <= l1;
        end
    end

    // NOTE: datapath registers carry no reset; the valid tags alone qualify them.
    always_ff @(posedge clk) begin
        p_ii <= P_W'(w_i) * P_W'(x_i);
        p_qq <= P_W'(w_q) * P_W'(x_q);
        p_iq <= P_W'(w_i) * P_W'(x_q);
        p_qi <= P_W'(w_q) * P_W'(x_i);
        re   <= S_W'(p_ii) + S_W'(p_qq);
        im   <= S_W'(p_iq) - S_W'(p_qi);
    end

endmodule

// File: rtl/conj_dot_accum.sv
// Streaming beamformer combiner: y = sum conj(w_k) * x_k over N_ELEM elements,
// rounded and saturated, one handshaked complex result per vector.
module conj_dot_accum
    import beamform_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_ELEM = 8,
    parameter int SHIFT  = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] w_q,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] x_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y_i,
    output logic signed [DATA_W-1:0] y_q,
    output logic                     sat
);

    localparam int ACC_W = acc_width(DATA_W, N_ELEM);
    localparam int SUM_W = 2 * DATA_W + 1;
    localparam int CNT_W = $clog2(N_ELEM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic                    in_xfer;
    logic                    v2, first2, last2;
    logic signed [SUM_W-1:0] re2, im2;
    logic signed [ACC_W-1:0] acc_re, acc_im, acc_re_nxt, acc_im_nxt;
    round_t                  rnd_re, rnd_im;

    assign in_ready = (state == ACC) && !rst;
    assign in_xfer  = in_valid && in_ready;

    cmul_conj #(.DATA_W(DATA_W)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_xfer),
        .in_first  (count == '0),
        .in_last   (count == LAST_IDX),
        .w_i       (w_i),
        .w_q       (w_q),
        .x_i       (x_i),
        .x_q       (x_q),
        .out_valid (v2),
        .out_first (first2),
        .out_last  (last2),
        .re        (re2),
        .im        (im2)
    );

    // NOTE: every always_comb output is fully assigned on every path, so no latch.
    always_comb begin
        acc_re_nxt = first2 ? ACC_W'(re2) : acc_re + ACC_W'(re2);
        acc_im_nxt = first2 ? ACC_W'(im2) : acc_im + ACC_W'(im2);
        rnd_re     = sat_round(RND_W'(acc_re_nxt), SHIFT);
        rnd_im     = sat_round(RND_W'(acc_im_nxt), SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            count     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            out_valid <= 1'b0;
            y_i       <= '0;
            y_q       <= '0;
            sat       <= 1'b0;
        end else begin
            if (in_xfer)
                count <= (count == LAST_IDX) ? '0 : count + CNT_W'(1);
            if (v2) begin
                acc_re <= acc_re_nxt;
                acc_im <= acc_im_nxt;
            end
            case (state)
                ACC: if (in_xfer && count == LAST_IDX) state <= DRAIN;
                // The last element reaches the accumulator; publish its final sum.
                DRAIN: if (v2 && last2) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    y_i       <= DATA_W'(rnd_re.y);
                    y_q       <= DATA_W'(rnd_im.y);
                    sat       <= rnd_re.clip | rnd_im.clip;
                end
                HOLD: if (out_ready) begin
                    state     <= ACC;
                    out_valid <= 1'b0;
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_conj_dot_accum.sv
// Bench for conj_dot_accum: table vectors, random vectors with gaps,
// backpressure and mid-vector reset, checked through an output scoreboard.
module tb_conj_dot_accum;

    localparam int N  = 8;
    localparam int DW = 18;
    localparam int SH = 17;

    typedef struct packed {
        logic [N-1:0][DW-1:0] wi, wq, xi, xq;
        logic [DW-1:0]        ey_i, ey_q;
        logic                 esat;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] yi, yq;
        logic          s;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 in_ready, out_valid, sat;
    logic signed [DW-1:0] w_i = '0, w_q = '0, x_i = '0, x_q = '0;
    logic        [DW-1:0] y_i, y_q;
    bit                   is_last = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   last_cyc = -100;
    bit   ov_prev = 1'b0;
    exp_t q[$];
    vec_t tbl[8];

    conj_dot_accum #(.N_ELEM(N), .SHIFT(SH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_i       (w_i),
        .w_q       (w_q),
        .x_i       (x_i),
        .x_q       (x_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_i       (y_i),
        .y_q       (y_q),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
        finish_run();
    endtask

    function automatic vec_t mk(input int wi, input int wq, input int xi, input int xq,
                                input bit all8, input int yi, input int yq, input bit s);
        vec_t v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (all8 || k == 0) begin
                v.wi[k] = DW'(wi);
                v.wq[k] = DW'(wq);
                v.xi[k] = DW'(xi);
                v.xq[k] = DW'(xq);
            end
        end
        v.ey_i = DW'(yi);
        v.ey_q = DW'(yq);
        v.esat = s;
        return v;
    endfunction

    function automatic int rnd_val(input int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    function automatic vec_t rnd_vec(input int mag);
        vec_t v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v.wi[k] = DW'(rnd_val(mag));
            v.wq[k] = DW'(rnd_val(mag));
            v.xi[k] = DW'(rnd_val(mag));
            v.xq[k] = DW'(rnd_val(mag));
        end
        return v;
    endfunction

    function automatic longint sat_ref(input longint acc, output bit clip);
        longint r;
        r = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        clip = 1'b0;
        if (r > 131071) begin r = 131071; clip = 1'b1; end
        if (r < -131072) begin r = -131072; clip = 1'b1; end
        return r;
    endfunction

    // Reference model: full-precision conj(w)*x sum, then round and saturate.
    function automatic vec_t model(input vec_t v);
        longint re, im, ri, rq, a, b, c, d;
        bit     ci, cq;
        re = 0;
        im = 0;
        for (int k = 0; k < N; k++) begin
            a = $signed(v.wi[k]);
            b = $signed(v.wq[k]);
            c = $signed(v.xi[k]);
            d = $signed(v.xq[k]);
            re += a * c + b * d;
            im += a * d - b * c;
        end
        ri = sat_ref(re, ci);
        rq = sat_ref(im, cq);
        v.ey_i = ri[DW-1:0];
        v.ey_q = rq[DW-1:0];
        v.esat = ci | cq;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        q.push_back('{yi: v.ey_i, yq: v.ey_q, s: v.esat});
    endtask

    // Called at posedge+1; returns how many cycles in_ready held the element off.
    task automatic send_elem(input logic [DW-1:0] wi, input logic [DW-1:0] wq,
                             input logic [DW-1:0] xi, input logic [DW-1:0] xq,
                             input bit last, output int waited);
        bit done;
        w_i = wi; w_q = wq; x_i = xi; x_q = xq;
        is_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else if (++waited > 200) timeout("in_ready");
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input bit gaps, input int n, output int first_wait);
        int w;
        first_wait = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0)
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_elem(v.wi[k], v.wq[k], v.xi[k], v.xq[k], k == N - 1, w);
            if (k == 0) first_wait = w;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            if (++b > 100) timeout("drain");
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: latency of each result and scoreboard compare on transfer.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst) begin
            if (in_valid && in_ready && is_last) last_cyc = ncyc;
            if (out_valid && !ov_prev) check("latency", ncyc - last_cyc, 3);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("y_i", y_i, e.yi);
                    check("y_q", y_q, e.yq);
                    check("sat", sat, e.s);
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        int   w, b;
        vec_t v;

        tbl[0] = mk(65536, 0, 16384, 0, 1, 65536, 0, 0);
        tbl[1] = mk(0, 65536, 65536, 0, 0, 0, -32768, 0);
        tbl[2] = mk(256, 0, 256, 0, 0, 1, 0, 0);
        tbl[3] = mk(255, 0, 257, 0, 0, 0, 0, 0);
        tbl[4] = mk(65536, 0, 65536, 0, 1, 131071, 0, 1);
        tbl[5] = mk(65536, 0, -65536, 0, 1, -131072, 0, 1);
        tbl[6] = mk(-131072, -131072, -131072, -131072, 1, 131071, 0, 1);
        tbl[7] = mk(1000, -2000, 3000, 4000, 0, -38, 76, 0);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_i", y_i, 0);
        check("rst_y_q", y_q, 0);
        check("rst_sat", sat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) begin
            push_exp(tbl[i]);
            send_vec(tbl[i], 1'b0, N, w);
        end
        drain();

        // Random vectors with input gaps, small to full-scale magnitudes
        foreach (tbl[i]) begin
            if (i < 3) begin
                v = model(rnd_vec(i == 0 ? 4095 : (i == 1 ? 40000 : 131071)));
                push_exp(v);
                send_vec(v, 1'b1, N, w);
            end
        end
        drain();

        // Backpressure: result held for 10 cycles, next vector right after transfer
        out_ready = 1'b0;
        push_exp(tbl[0]);
        send_vec(tbl[0], 1'b0, N, w);
        b = 0;
        do begin
            @(negedge clk);
            if (++b > 20) timeout("out_valid");
        end while (!out_valid);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_y_i", y_i, 65536);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_exp(tbl[1]);
        send_vec(tbl[1], 1'b0, N, w);
        check("bp_next_accept_wait", w, 0);
        drain();

        // Reset after 5 elements, then a fresh gapped vector
        v = rnd_vec(50000);
        send_vec(v, 1'b0, 5, w);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y_q", y_q, 0);
        check("mid_rst_sat", sat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        v = model(rnd_vec(50000));
        push_exp(v);
        send_vec(v, 1'b1, N, w);
        drain();

        check("queue_empty", q.size(), 0);
        finish_run();
    end

endmodule
